// File: rtl/kernel_prueba_example_control_if.sv
// Bundle of the host control/argument signals and the vadd launch/complete
// signals of the kernel control sequencer.
//   slave  : sequencer view (host start, arguments and vadd k_done in;
//            ap_* status, latched k_* arguments, k_start and run_cycles out)
//   master : environment view (host plus vadd), the mirror of slave
interface kernel_prueba_example_control_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CYCLE_CNT_WIDTH  = 32
) ();
  logic                          ap_start;
  logic                          ap_idle;
  logic                          ap_done;
  logic                          ap_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] arg_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  arg_xfer_size_in_bytes;
  logic [C_ADDER_BIT_WIDTH-1:0]  arg_constant;
  logic                          k_start;
  logic                          k_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] k_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  k_xfer_size_in_bytes;
  logic [C_ADDER_BIT_WIDTH-1:0]  k_constant;
  logic [C_CYCLE_CNT_WIDTH-1:0]  run_cycles;

  modport slave (
    input  ap_start, arg_addr_offset, arg_xfer_size_in_bytes, arg_constant, k_done,
    output ap_idle, ap_done, ap_ready, k_start, k_addr_offset,
           k_xfer_size_in_bytes, k_constant, run_cycles
  );

  modport master (
    output ap_start, arg_addr_offset, arg_xfer_size_in_bytes, arg_constant, k_done,
    input  ap_idle, ap_done, ap_ready, k_start, k_addr_offset,
           k_xfer_size_in_bytes, k_constant, run_cycles
  );
endinterface

// File: rtl/kernel_prueba_example_control.sv
// Kernel control sequencer placed in front of the vadd datapath. It runs the
// ap_ctrl_hs host handshake, captures and normalises the scalar arguments once
// per run, fires a one-cycle k_start to the vadd, waits for k_done and counts
// the cycles the run took.
// Ports:
//   aclk   : sole clock
//   areset : asynchronous active-high reset
//   ctrl   : kernel_prueba_example_control_if.slave (ap_* handshake, arg_*
//            inputs, k_* launch/complete and latched arguments, run_cycles)
module kernel_prueba_example_control #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CYCLE_CNT_WIDTH  = 32
) (
  input logic aclk,
  input logic areset,
  kernel_prueba_example_control_if.slave ctrl
);

  localparam int DWB      = C_M_AXI_DATA_WIDTH / 8;
  localparam int DWB_LOG2 = $clog2(DWB);
  localparam int AW       = C_M_AXI_ADDR_WIDTH;
  localparam int XW       = C_XFER_SIZE_WIDTH;
  localparam int CW       = C_CYCLE_CNT_WIDTH;

  // Masks that clear the byte-within-beat bits.
  localparam logic [AW-1:0] ADDR_MASK = {{(AW-DWB_LOG2){1'b1}}, {DWB_LOG2{1'b0}}};
  localparam logic [XW-1:0] SIZE_MASK = {{(XW-DWB_LOG2){1'b1}}, {DWB_LOG2{1'b0}}};
  localparam logic [XW:0]   BEAT_M1   = {{(XW+1-DWB_LOG2){1'b0}}, {DWB_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                        state_r;
  state_t                        state_next_s;
  logic                          latch_s;
  logic [XW:0]                   size_sum_s;
  logic [XW-1:0]                 size_round_s;
  logic [AW-1:0]                 addr_align_s;

  logic                          ap_idle_r;
  logic                          ap_done_r;
  logic                          ap_ready_r;
  logic                          k_start_r;
  logic [AW-1:0]                 k_addr_offset_r;
  logic [XW-1:0]                 k_xfer_size_r;
  logic [C_ADDER_BIT_WIDTH-1:0]  k_constant_r;
  logic [CW-1:0]                 run_cycles_r;

  // Argument normalisation: align the address, round the size up to whole
  // beats; the extra carry bit of the sum flags a round-up that no longer fits.
  always_comb begin
    addr_align_s = ctrl.arg_addr_offset & ADDR_MASK;
    size_sum_s   = {1'b0, ctrl.arg_xfer_size_in_bytes} + BEAT_M1;
    if (size_sum_s[XW]) begin
      size_round_s = SIZE_MASK;
    end else begin
      size_round_s = size_sum_s[XW-1:0] & SIZE_MASK;
    end
  end

  // Next-state logic; latch_s marks the single cycle where arguments are taken.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl.ap_start) begin
          latch_s = 1'b1;
          if (size_round_s == {XW{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_LAUNCH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_next_s = ST_BUSY;
      ST_BUSY: begin
        if (ctrl.k_done) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Status/launch outputs are registered from the next state so each one is
  // valid in the same cycle the FSM occupies the matching state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ap_idle_r  <= 1'b1;
      ap_done_r  <= 1'b0;
      ap_ready_r <= 1'b0;
      k_start_r  <= 1'b0;
    end else begin
      ap_idle_r  <= (state_next_s == ST_IDLE);
      ap_done_r  <= (state_next_s == ST_DONE);
      ap_ready_r <= (state_next_s == ST_DONE);
      k_start_r  <= (state_next_s == ST_LAUNCH);
    end
  end

  // Argument capture; held until the next run is accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      k_addr_offset_r <= {AW{1'b0}};
      k_xfer_size_r   <= {XW{1'b0}};
      k_constant_r    <= {C_ADDER_BIT_WIDTH{1'b0}};
    end else if (latch_s) begin
      k_addr_offset_r <= addr_align_s;
      k_xfer_size_r   <= size_round_s;
      k_constant_r    <= ctrl.arg_constant;
    end
  end

  // Run-cycle counter: cleared on latch, counts LAUNCH and BUSY cycles,
  // saturating at all-ones.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_cycles_r <= {CW{1'b0}};
    end else if (latch_s) begin
      run_cycles_r <= {CW{1'b0}};
    end else if (((state_r == ST_LAUNCH) || (state_r == ST_BUSY)) &&
                 (run_cycles_r != {CW{1'b1}})) begin
      run_cycles_r <= run_cycles_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign ctrl.ap_idle              = ap_idle_r;
  assign ctrl.ap_done              = ap_done_r;
  assign ctrl.ap_ready             = ap_ready_r;
  assign ctrl.k_start              = k_start_r;
  assign ctrl.k_addr_offset        = k_addr_offset_r;
  assign ctrl.k_xfer_size_in_bytes = k_xfer_size_r;
  assign ctrl.k_constant           = k_constant_r;
  assign ctrl.run_cycles           = run_cycles_r;

endmodule

// File: tb/tb_kernel_prueba_example_control.sv
// Directed self-checking bench for kernel_prueba_example_control.
module tb_kernel_prueba_example_control;

  logic aclk;
  logic areset;
  int   tests_run;
  int   tests_failed;
  int   kstart_cnt;
  int   done_cnt;

  kernel_prueba_example_control_if #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH (32),
    .C_ADDER_BIT_WIDTH (32),
    .C_CYCLE_CNT_WIDTH (32)
  ) ctrl ();

  kernel_prueba_example_control #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_M_AXI_DATA_WIDTH(512),
    .C_XFER_SIZE_WIDTH (32),
    .C_ADDER_BIT_WIDTH (32),
    .C_CYCLE_CNT_WIDTH (32)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .ctrl  (ctrl.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the active edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_args(input logic [63:0] a, input logic [31:0] s, input logic [31:0] c);
    ctrl.arg_addr_offset        = a;
    ctrl.arg_xfer_size_in_bytes = s;
    ctrl.arg_constant           = c;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    areset       = 1'b1;
    ctrl.ap_start = 1'b0;
    ctrl.k_done   = 1'b0;
    set_args(64'h0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    check("rst_idle",   {63'h0, ctrl.ap_idle}, 64'h1);
    check("rst_done",   {63'h0, ctrl.ap_done}, 64'h0);
    check("rst_ready",  {63'h0, ctrl.ap_ready}, 64'h0);
    check("rst_kstart", {63'h0, ctrl.k_start}, 64'h0);
    check("rst_addr",   ctrl.k_addr_offset, 64'h0);
    check("rst_size",   {32'h0, ctrl.k_xfer_size_in_bytes}, 64'h0);
    check("rst_const",  {32'h0, ctrl.k_constant}, 64'h0);
    check("rst_cycles", {32'h0, ctrl.run_cycles}, 64'h0);
    areset = 1'b0;
    tick();

    // Basic run: k_done 20 cycles after k_start -> run_cycles 21
    set_args(64'h1000, 32'd4096, 32'd5);
    ctrl.ap_start = 1'b1;
    tick();
    check("basic_kstart", {63'h0, ctrl.k_start}, 64'h1);
    check("basic_idle_low", {63'h0, ctrl.ap_idle}, 64'h0);
    check("basic_addr",  ctrl.k_addr_offset, 64'h1000);
    check("basic_size",  {32'h0, ctrl.k_xfer_size_in_bytes}, 64'd4096);
    check("basic_const", {32'h0, ctrl.k_constant}, 64'd5);
    kstart_cnt = 0;
    done_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      kstart_cnt += int'(ctrl.k_start);
      done_cnt   += int'(ctrl.ap_done);
    end
    check("basic_one_kstart", 64'(kstart_cnt), 64'd0);
    check("basic_no_early_done", 64'(done_cnt), 64'd0);
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("basic_done",   {63'h0, ctrl.ap_done}, 64'h1);
    check("basic_ready",  {63'h0, ctrl.ap_ready}, 64'h1);
    check("basic_cycles", {32'h0, ctrl.run_cycles}, 64'd21);
    ctrl.ap_start = 1'b0;
    tick();
    check("basic_done_pulse",  {63'h0, ctrl.ap_done}, 64'h0);
    check("basic_ready_pulse", {63'h0, ctrl.ap_ready}, 64'h0);
    check("basic_idle_back",   {63'h0, ctrl.ap_idle}, 64'h1);
    check("basic_cycles_held", {32'h0, ctrl.run_cycles}, 64'd21);
    tick();

    // Rounding/alignment; ap_start dropped during the run has no effect
    set_args(64'h1234_5678, 32'd100, 32'd3);
    ctrl.ap_start = 1'b1;
    tick();
    ctrl.ap_start = 1'b0;
    check("round_addr",   ctrl.k_addr_offset, 64'h1234_5640);
    check("round_size",   {32'h0, ctrl.k_xfer_size_in_bytes}, 64'd128);
    check("round_kstart", {63'h0, ctrl.k_start}, 64'h1);
    tick();
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("round_done",   {63'h0, ctrl.ap_done}, 64'h1);
    check("round_cycles", {32'h0, ctrl.run_cycles}, 64'd2);
    tick();
    tick();

    // Saturation; k_done in the first BUSY cycle
    set_args(64'h40, 32'hFFFF_FFF0, 32'hDEAD_BEEF);
    ctrl.ap_start = 1'b1;
    tick();
    ctrl.ap_start = 1'b0;
    check("sat_size",  {32'h0, ctrl.k_xfer_size_in_bytes}, 64'hFFFF_FFC0);
    check("sat_const", {32'h0, ctrl.k_constant}, 64'hDEAD_BEEF);
    tick();
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("sat_done",   {63'h0, ctrl.ap_done}, 64'h1);
    check("sat_cycles", {32'h0, ctrl.run_cycles}, 64'd2);
    tick();
    tick();

    // Zero size: no launch, done next cycle, run_cycles cleared
    set_args(64'h80, 32'd0, 32'd1);
    ctrl.ap_start = 1'b1;
    tick();
    ctrl.ap_start = 1'b0;
    check("zero_kstart", {63'h0, ctrl.k_start}, 64'h0);
    check("zero_done",   {63'h0, ctrl.ap_done}, 64'h1);
    check("zero_ready",  {63'h0, ctrl.ap_ready}, 64'h1);
    check("zero_cycles", {32'h0, ctrl.run_cycles}, 64'd0);
    check("zero_size",   {32'h0, ctrl.k_xfer_size_in_bytes}, 64'd0);
    tick();
    check("zero_done_pulse", {63'h0, ctrl.ap_done}, 64'h0);
    check("zero_kstart2",    {63'h0, ctrl.k_start}, 64'h0);
    check("zero_idle",       {63'h0, ctrl.ap_idle}, 64'h1);
    tick();

    // Back-to-back with arguments changed after the first latch
    set_args(64'h2000, 32'd64, 32'd7);
    ctrl.ap_start = 1'b1;
    tick();
    check("b2b_kstart1", {63'h0, ctrl.k_start}, 64'h1);
    set_args(64'h3000, 32'd200, 32'd9);
    tick();
    check("b2b_addr_hold",  ctrl.k_addr_offset, 64'h2000);
    check("b2b_size_hold",  {32'h0, ctrl.k_xfer_size_in_bytes}, 64'd64);
    check("b2b_const_hold", {32'h0, ctrl.k_constant}, 64'd7);
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("b2b_done1", {63'h0, ctrl.ap_done}, 64'h1);
    tick();
    check("b2b_idle_gap", {63'h0, ctrl.ap_idle}, 64'h1);
    ctrl.k_done = 1'b1;   // stray pulse while IDLE
    tick();
    ctrl.k_done = 1'b0;
    ctrl.ap_start = 1'b0;
    check("b2b_kstart2", {63'h0, ctrl.k_start}, 64'h1);
    check("b2b_stray_nodone", {63'h0, ctrl.ap_done}, 64'h0);
    check("b2b_addr2",  ctrl.k_addr_offset, 64'h3000);
    check("b2b_size2",  {32'h0, ctrl.k_xfer_size_in_bytes}, 64'd256);
    check("b2b_const2", {32'h0, ctrl.k_constant}, 64'd9);
    tick();
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("b2b_done2",   {63'h0, ctrl.ap_done}, 64'h1);
    check("b2b_cycles2", {32'h0, ctrl.run_cycles}, 64'd2);
    tick();
    tick();
    ctrl.k_done = 1'b1;   // stray pulse in idle, no start
    tick();
    ctrl.k_done = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      done_cnt += int'(ctrl.ap_done);
      tick();
    end
    check("stray_idle_nodone", 64'(done_cnt), 64'd0);
    check("stray_idle_idle",   {63'h0, ctrl.ap_idle}, 64'h1);

    // Reset mid-BUSY, then a late k_done
    set_args(64'h5000, 32'd640, 32'd11);
    ctrl.ap_start = 1'b1;
    tick();
    ctrl.ap_start = 1'b0;
    check("rb_kstart", {63'h0, ctrl.k_start}, 64'h1);
    for (int i = 0; i < 5; i++) tick();
    check("rb_busy_cycles", {32'h0, ctrl.run_cycles}, 64'd5);
    areset = 1'b1;
    #1;
    check("rb_idle",   {63'h0, ctrl.ap_idle}, 64'h1);
    check("rb_addr",   ctrl.k_addr_offset, 64'h0);
    check("rb_size",   {32'h0, ctrl.k_xfer_size_in_bytes}, 64'h0);
    check("rb_const",  {32'h0, ctrl.k_constant}, 64'h0);
    check("rb_cycles", {32'h0, ctrl.run_cycles}, 64'h0);
    tick();
    tick();
    areset = 1'b0;
    ctrl.k_done = 1'b1;
    tick();
    ctrl.k_done = 1'b0;
    check("rb_late_nodone", {63'h0, ctrl.ap_done}, 64'h0);
    check("rb_late_nostart", {63'h0, ctrl.k_start}, 64'h0);
    tick();
    check("rb_late_nodone2", {63'h0, ctrl.ap_done}, 64'h0);
    check("rb_late_idle",    {63'h0, ctrl.ap_idle}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kernel_prueba_example_control.md
# kernel_prueba_example_control

Kernel control sequencer sitting directly upstream of the vadd datapath top. It implements the host-side ap_ctrl_hs handshake (ap_start/ap_idle/ap_done/ap_ready) and captures the scalar arguments once per run. It normalises those arguments and issues a single-cycle launch pulse to the vadd. It waits for the vadd completion pulse and counts the cycles the run took.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, byte address width of ctrl_addr_offset.
- C_M_AXI_DATA_WIDTH, 512, datapath width; defines beat size DWB = C_M_AXI_DATA_WIDTH/8 bytes.
- C_XFER_SIZE_WIDTH, 32, width of transfer size in bytes.
- C_ADDER_BIT_WIDTH, 32, width of the adder constant.
- C_CYCLE_CNT_WIDTH, 32, width of the run-cycle counter.

Ports:
- aclk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- ap_start  in  1  host start level.
- ap_idle  out  1  block idle.
- ap_done  out  1  run complete, one-cycle pulse.
- ap_ready  out  1  arguments consumed, one-cycle pulse, coincident with ap_done.
- arg_addr_offset  in  C_M_AXI_ADDR_WIDTH  host buffer base address.
- arg_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  host transfer size.
- arg_constant  in  C_ADDER_BIT_WIDTH  host adder constant.
- k_start  out  1  launch pulse to vadd.
- k_done  in  1  completion pulse from vadd.
- k_addr_offset  out  C_M_AXI_ADDR_WIDTH  latched, aligned address.
- k_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  latched, rounded size.
- k_constant  out  C_ADDER_BIT_WIDTH  latched constant.
- run_cycles  out  C_CYCLE_CNT_WIDTH  cycles of the last or current run.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE. All outputs are registered.
- IDLE:
  - ap_idle=1.
  - On ap_start=1, latch the arguments and clear run_cycles.
  - If the rounded size is 0, go to DONE; otherwise go to LAUNCH.
- LAUNCH: k_start=1 for exactly one cycle, then go to BUSY.
- BUSY: wait for k_done=1, then go to DONE.
- DONE: ap_done=1 and ap_ready=1 for one cycle, then go to IDLE.
- Address alignment: k_addr_offset = arg_addr_offset with its low log2(DWB) bits forced to 0.
- Size rounding: k_xfer_size_in_bytes = arg_xfer_size_in_bytes rounded up to a multiple of DWB.
  - If the round-up overflows, saturate to the largest multiple of DWB that fits in C_XFER_SIZE_WIDTH.
  - An input of 0 stays 0; the vadd is never launched for a zero size.
- k_addr_offset, k_xfer_size_in_bytes and k_constant are stable from LAUNCH until the next latch. Argument changes after the latch are ignored.
- run_cycles: increments once per cycle in LAUNCH and BUSY. It saturates at all-ones and is held in DONE/IDLE until the next latch.
- k_done outside BUSY is ignored; a stray pulse produces no ap_done.
- ap_start still 1 in the IDLE cycle after DONE starts a back-to-back run, re-latching the arguments.
- ap_start deasserted during LAUNCH/BUSY has no effect; the run completes.

## Timing
- Reset values:
  - ap_idle=1.
  - ap_done, ap_ready, k_start = 0.
  - k_* argument outputs and run_cycles = 0.
  - State = IDLE.
- Reset mid-run returns to IDLE immediately and asynchronously. An in-flight k_done arriving after reset release is ignored.
- Latency with ap_start sampled high at edge N:
  - ap_idle falls after N.
  - k_start is high in cycle N+1.
  - BUSY begins at N+2.
- k_done sampled at edge M in BUSY: ap_done/ap_ready are high in cycle M+1, and ap_idle rises in cycle M+2.
- run_cycles at ap_done = M-N: one count for LAUNCH plus one for each BUSY cycle, including the k_done cycle.
- Zero size: ap_start sampled at N gives ap_done in cycle N+1 and run_cycles=0.
- k_done in the first BUSY cycle (N+2) is legal: ap_done in N+3, run_cycles=2.

## Test plan
- Basic run:
  - Stimulus: addr=0x1000, size=4096, const=5, ap_start held; k_done is pulsed 20 cycles after k_start.
  - Response: exactly one k_start; k outputs 0x1000/4096/5; ap_done and ap_ready a single cycle; run_cycles=21; ap_idle returns.
- Rounding and alignment:
  - Stimulus: addr=0x1234_5678, size=100.
  - Response: k_addr_offset=0x1234_5640, k_xfer_size_in_bytes=128.
- Saturation:
  - Stimulus: size=0xFFFF_FFF0.
  - Response: k_xfer_size_in_bytes=0xFFFF_FFC0.
- Zero size:
  - Stimulus: size=0.
  - Response: no k_start; ap_done one cycle after the start sample; run_cycles=0.
- Back-to-back and stray k_done:
  - Stimulus: ap_start held across two runs with the arguments changed after the first latch; k_done also pulsed while in IDLE.
  - Response: the second run uses the new arguments, latched in the IDLE cycle; the stray pulse gives no ap_done.
- Reset mid-BUSY:
  - Stimulus: assert areset 5 cycles into BUSY, then release.
  - Response: all outputs return to reset values; a late k_done produces no ap_done.
